// File: rtl/seg7_pkg.sv
// Shared constants for the active-low 7-segment bus: digit patterns, invalid code, capture FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      LOCKED
   } state_t;

endpackage

// File: rtl/seg7_pat2bcd.sv
// Combinational active-low segment pattern to BCD decoder; unknown patterns give valid=0 and BCD_INVALID.
module seg7_pat2bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       valid,
   output logic [3:0] bcd
);

   always_comb begin
      valid = 1'b1;
      bcd   = BCD_INVALID;
      case (seg_n)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low 7-segment bus, captures each digit once it has been stable for
// STABLE_CYCLES samples (capture STABLE_CYCLES edges after the sample register loads), no backpressure.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter  int NUM_DIGITS    = 2,
   parameter  int STABLE_CYCLES = 4,
   localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   err,
   output logic                    upd,
   output logic [IDX_W-1:0]        upd_idx
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [6:0]            samp_seg;
   logic [6:0]            prev_seg;
   logic [NUM_DIGITS-1:0] samp_an;
   logic [NUM_DIGITS-1:0] prev_an;
   logic [NUM_DIGITS-1:0] an_act;
   logic                  legal;
   logic                  same;
   logic [IDX_W-1:0]      idx;
   logic                  pat_valid;
   logic [3:0]            pat_bcd;
   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic                  capture;

   // Blank (all ones) reset value keeps the FSM in IDLE until a real anode appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_seg <= '1;
         samp_an  <= '1;
         prev_seg <= '1;
         prev_an  <= '1;
      end else begin
         samp_seg <= seg_n;
         samp_an  <= an_n;
         prev_seg <= samp_seg;
         prev_an  <= samp_an;
      end
   end

   assign an_act = ~samp_an;
   assign legal  = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
   assign same   = (samp_seg == prev_seg) && (samp_an == prev_an);

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_act[i]) idx = IDX_W'(i);
      end
   end

   seg7_pat2bcd u_pat2bcd (
      .seg_n (samp_seg),
      .valid (pat_valid),
      .bcd   (pat_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (legal) begin
               state_nxt = TRACK;
               count_nxt = CNT_ONE;
            end
         end
         TRACK: begin
            if (!legal) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (same) begin
               if (count != CNT_MAX) count_nxt = count + CNT_ONE;
            end else begin
               count_nxt = CNT_ONE;
            end
         end
         LOCKED: begin
            if (!legal) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (!same) begin
               state_nxt = TRACK;
               count_nxt = CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
      // A run completes the moment the count lands on STABLE_CYCLES, including the restart value 1.
      if (state_nxt == TRACK && count_nxt == CNT_MAX) begin
         capture   = 1'b1;
         state_nxt = LOCKED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_out <= '0;
         err        <= '0;
         upd        <= 1'b0;
         upd_idx    <= '0;
      end else begin
         upd <= capture;
         if (capture) begin
            upd_idx <= idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (IDX_W'(i) == idx) begin
                  digits_out[4*i +: 4] <= pat_bcd;
                  err[i]               <= ~pat_valid;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed, table-driven bench for seg7_capture with NUM_DIGITS=2, STABLE_CYCLES=4.
module tb_seg7_capture;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P6 = 7'b0000010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] PBLANK = 7'b1111111;
   localparam logic [6:0] PBAD   = 7'b1111110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg_n;
   logic [1:0] an_n;
   logic [7:0] digits_out;
   logic [1:0] err;
   logic       upd;
   logic [0:0] upd_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seg7_capture #(
      .NUM_DIGITS    (2),
      .STABLE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .digits_out (digits_out),
      .err        (err),
      .upd        (upd),
      .upd_idx    (upd_idx)
   );

   typedef struct {
      logic [6:0] seg;
      logic [1:0] an;
      int         hold;
      int         pulses;
      logic [0:0] idx;
      logic [7:0] digits;
      logic [1:0] err;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold a vector, then blank the anodes for two cycles so a capture landing late is still counted.
   task automatic run_vec(input vec_t v, input int k);
      int         pulses;
      logic [0:0] seen_idx;
      pulses   = 0;
      seen_idx = '0;
      seg_n    = v.seg;
      an_n     = v.an;
      for (int c = 0; c < v.hold + 2; c++) begin
         if (c == v.hold) an_n = 2'b11;
         tick();
         if (upd) begin
            pulses++;
            seen_idx = upd_idx;
         end
      end
      check($sformatf("vec%0d_pulses", k), pulses, v.pulses);
      if (v.pulses > 0) check($sformatf("vec%0d_idx", k), 32'(seen_idx), 32'(v.idx));
      check($sformatf("vec%0d_digits", k), 32'(digits_out), 32'(v.digits));
      check($sformatf("vec%0d_err", k), 32'(err), 32'(v.err));
   endtask

   initial begin
      tbl[0]  = '{P5,     2'b01,  6, 1, 1'b1, 8'h52, 2'b00};
      tbl[1]  = '{P7,     2'b10,  6, 1, 1'b0, 8'h57, 2'b00};
      tbl[2]  = '{P5,     2'b01,  6, 1, 1'b1, 8'h57, 2'b00};
      tbl[3]  = '{P7,     2'b10,  6, 1, 1'b0, 8'h57, 2'b00};
      tbl[4]  = '{PBLANK, 2'b01,  4, 1, 1'b1, 8'hF7, 2'b10};
      tbl[5]  = '{P0,     2'b01,  4, 1, 1'b1, 8'h07, 2'b00};
      tbl[6]  = '{P8,     2'b00, 10, 0, 1'b0, 8'h07, 2'b00};
      tbl[7]  = '{P8,     2'b11, 10, 0, 1'b0, 8'h07, 2'b00};
      tbl[8]  = '{PBAD,   2'b10,  4, 1, 1'b0, 8'h0F, 2'b01};
      tbl[9]  = '{P9,     2'b10,  3, 0, 1'b0, 8'h0F, 2'b01};
      tbl[10] = '{P9,     2'b10,  4, 1, 1'b0, 8'h09, 2'b00};
      tbl[11] = '{P6,     2'b01,  5, 1, 1'b1, 8'h69, 2'b00};
      tbl[12] = '{P1,     2'b01,  4, 1, 1'b1, 8'h19, 2'b00};
      tbl[13] = '{P3,     2'b10,  4, 1, 1'b0, 8'h13, 2'b00};

      rst_n = 1'b0;
      seg_n = PBLANK;
      an_n  = 2'b11;
      #12;
      check("rst_digits", 32'(digits_out), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_upd", 32'(upd), 32'h0);
      check("rst_idx", 32'(upd_idx), 32'h0);

      // First capture: pattern loads at edge 1, captured at edge 5, then held 10 more cycles.
      @(negedge clk);
      rst_n = 1'b1;
      seg_n = P2;
      an_n  = 2'b10;
      for (int c = 1; c <= 14; c++) begin
         tick();
         check($sformatf("lat_upd_c%0d", c), 32'(upd), (c == 5) ? 32'h1 : 32'h0);
         if (c == 5) begin
            check("lat_idx", 32'(upd_idx), 32'h0);
            check("lat_digit0", 32'(digits_out[3:0]), 32'h2);
            check("lat_err", 32'(err), 32'h0);
         end
      end
      an_n = 2'b11;
      tick();
      tick();

      for (int k = 0; k < 14; k++) run_vec(tbl[k], k);

      // Glitch on the edge the count would complete restarts the run.
      begin
         int pulses;
         pulses = 0;
         an_n   = 2'b10;
         for (int c = 1; c <= 9; c++) begin
            seg_n = (c == 4) ? P3 : P4;
            tick();
            if (c <= 8 && upd) pulses++;
            if (c == 9) begin
               check("glitch_upd", 32'(upd), 32'h1);
               check("glitch_digit0", 32'(digits_out[3:0]), 32'h4);
            end
         end
         check("glitch_early_pulses", pulses, 0);
      end

      // Lock digit 1, then move into TRACK and pull reset between clock edges.
      seg_n = P6;
      an_n  = 2'b01;
      for (int c = 0; c < 6; c++) tick();
      check("pre_rst_idx", 32'(upd_idx), 32'h1);
      seg_n = P8;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_digits", 32'(digits_out), 32'h0);
      check("arst_err", 32'(err), 32'h0);
      check("arst_upd", 32'(upd), 32'h0);
      check("arst_idx", 32'(upd_idx), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check($sformatf("post_rst_upd_c%0d", c), 32'(upd), (c == 5) ? 32'h1 : 32'h0);
         if (c == 5) begin
            check("post_rst_digits", 32'(digits_out), 32'h80);
            check("post_rst_idx", 32'(upd_idx), 32'h1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Monitor for the traffic-light controller's time-multiplexed 7-segment display bus: it samples the active-low segment and anode lines, waits until each digit's pattern is stable, and decodes it back to a 4-bit BCD value per digit. It is the reader at the far end of the 7-segment encoding. Its uses are on-board self-check and bench observation of the countdown display. Invalid segment patterns are flagged per digit rather than silently mapped.

## Interface
- NUM_DIGITS, 2, number of multiplexed digits (anode lines), ≥1
- STABLE_CYCLES, 4, consecutive identical samples required before capture, ≥1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active low, bit 6 = g … bit 0 = a
- an_n  in  NUM_DIGITS  anode enables, active low, bit i selects digit i
- digits_out  out  4*NUM_DIGITS  captured BCD, digit i in bits [4i+3:4i]
- err  out  NUM_DIGITS  sticky-until-recapture invalid-pattern flag per digit
- upd  out  1  one-cycle pulse: a digit was (re)captured
- upd_idx  out  $clog2(NUM_DIGITS) (min 1)  index of digit captured with upd

## Operation
- Decode table, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Any other seg_n value is invalid: the captured value is 4'hF and err[i] is set.
- A valid capture of digit i writes the decoded value and clears err[i].
- Inputs are registered once (sample register) before any comparison. The previous sample is also held for comparison.
- Anode is legal only when exactly one bit of an_n is 0. All-ones (blank) or multiple lows is illegal.
- FSM states:
  - IDLE: no legal anode.
  - TRACK: counting stable samples.
  - LOCKED: pattern already captured; waiting for a change.
- IDLE→TRACK: a legal anode sample arrives; count=1.
- TRACK:
  - Sample equal to the previous (seg_n and an_n) increments count.
  - Sample differs but is legal: count=1, stay TRACK.
  - Illegal anode: go to IDLE.
  - count reaches STABLE_CYCLES: capture, go to LOCKED.
- LOCKED:
  - Identical sample: hold, no further upd.
  - Any change with a legal anode: TRACK, count=1.
  - Illegal anode: IDLE.
- STABLE_CYCLES=1: every legal sample that differs from the previous one captures immediately (IDLE/TRACK→LOCKED on that sample).
- Count width is $clog2(STABLE_CYCLES+1). Count saturates and never wraps.
- Digits not currently being driven keep their last captured value.

## Timing
- Reset values:
  - digits_out = 0
  - err = 0
  - upd = 0
  - upd_idx = 0
  - state = IDLE, count = 0, both sample registers = all ones (blank)
- Latency: a pattern first present on the pins before edge t reaches the sample register at edge t. If it is held, capture happens at edge t+STABLE_CYCLES, and upd is high for exactly one cycle after that edge.
- digits_out, err and upd_idx change on the same edge that upd rises.
- A pattern that changes on the same edge the count would reach STABLE_CYCLES is not captured; the new pattern restarts at count=1.
- Reset asserted mid-TRACK or mid-LOCKED returns all outputs to their reset values immediately (asynchronous). After release, the first capture needs a full STABLE_CYCLES run.
- No combinational path from inputs to outputs.

## Structure
- Package seg7_pkg holds:
  - the ten active-low segment constants (shared with the existing display decoder)
  - the invalid-value code 4'hF
  - the FSM state enum {IDLE, TRACK, LOCKED}
- Sub-module seg7_pat2bcd is a combinational pattern→{valid, bcd[3:0]} decoder, instantiated once on the sample register.
- Top level holds the sample/previous registers, legality check, counter, FSM and the per-digit result registers.

## Test plan
- Reset then hold seg_n=0100100, an_n=10 (digit 0) for 4 cycles. Required: upd pulses once, upd_idx=0, digits_out[3:0]=2, err=00. No second pulse while the pattern is held 10 more cycles.
- Alternate digit 1 = 0010010 (5) and digit 0 = 1111000 (7), each held 6 cycles. Required: digits_out=8'h57, one upd per dwell, upd_idx alternating 1/0.
- Hold seg_n=1111111 (blank pattern) with an_n=01 for 4 cycles. Required: digits_out[7:4]=F, err[1]=1. Then 1000000 for 4 cycles: digits_out[7:4]=0, err[1]=0.
- Glitch: 3 cycles of 0011001, 1 cycle of 0110000, 3 cycles of 0011001 on digit 0. Required: no upd. Then a 4th consecutive 0011001 cycle: capture value 4.
- Illegal anode: an_n=00 or 11 with a valid seg_n for 10 cycles. Required: no upd and digits_out unchanged. Also assert rst_n low mid-TRACK: outputs go to 0 without waiting for a clock edge.
